// File: rtl/rca_seq_ctrl.sv
// Multi-cycle WIDTH-bit add/subtract built on one shared 4-bit ripple-carry adder.
// Operands are consumed one nibble per clock, LSB first, with the carry held in a register.

module rca (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [4:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign cout = w_c[4];
endmodule

// WIDTH must be a multiple of 4 and at least 4.
module rca_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [1:0]       dbg_state
);
    localparam int NSLICE = WIDTH / 4;
    localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_w;
    logic [WIDTH-1:0] r_b_w;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic [KW-1:0]    r_k;
    logic             r_a_msb;
    logic             r_eff_b_msb;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic [3:0]       w_rca_sum;
    logic             w_rca_cout;
    logic [WIDTH-1:0] w_res_next;
    logic             w_last;

    rca u_rca (
        .a    (r_a_w[3:0]),
        .b    (r_b_w[3:0]),
        .cin  (r_carry),
        .sum  (w_rca_sum),
        .cout (w_rca_cout)
    );

    // Each new nibble enters at the top, so after NSLICE shifts the LSB slice sits at bit 0.
    if (WIDTH == 4) begin : g_one_slice
        assign w_res_next = w_rca_sum;
    end else begin : g_multi_slice
        assign w_res_next = {w_rca_sum, r_res[WIDTH-1:4]};
    end

    assign w_last = (r_k == KW'(NSLICE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_a_w       <= '0;
            r_b_w       <= '0;
            r_res       <= '0;
            r_carry     <= 1'b0;
            r_k         <= '0;
            r_a_msb     <= 1'b0;
            r_eff_b_msb <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        // Subtraction is A + ~B + 1, so cin is replaced by the forced 1.
                        r_a_w       <= a;
                        r_b_w       <= sub ? ~b : b;
                        r_carry     <= sub ? 1'b1 : cin;
                        r_a_msb     <= a[WIDTH-1];
                        r_eff_b_msb <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
                        r_k         <= '0;
                        r_state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_a_w   <= r_a_w >> 4;
                    r_b_w   <= r_b_w >> 4;
                    r_res   <= w_res_next;
                    r_carry <= w_rca_cout;
                    r_k     <= r_k + 1'b1;
                    if (w_last) begin
                        r_sum   <= w_res_next;
                        r_cout  <= w_rca_cout;
                        r_ovf   <= (r_a_msb == r_eff_b_msb) && (w_res_next[WIDTH-1] != r_a_msb);
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign dbg_state = r_state;
endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Bench for rca_seq_ctrl: directed and random operations, integer reference model,
// expected-result queue drained by an independent monitor.

module tb_rca_seq_ctrl;
  localparam int W      = 16;
  localparam int NSLICE = W / 4;
  localparam int RW     = W + 2;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          cin;
  logic          sub;
  logic          busy;
  logic          done;
  logic [W-1:0]  sum;
  logic          cout;
  logic          ovf;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [RW-1:0] exp_q[$];
  int            exp_t_q[$];
  logic [RW-1:0] last_res;

  rca_seq_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // reference model: {sum, cout, ovf} from plain integer arithmetic
  function automatic logic [RW-1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                          input logic mcin, input logic msub);
    longint ua, ub, ur, sa, sb, sr;
    logic [W-1:0] rs;
    logic rc, ro;
    ua = longint'(ma);
    ub = longint'(mb);
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    if (msub) begin
      ur = ua - ub;
      rc = (ua >= ub);
      sr = sa - sb;
    end else begin
      ur = ua + ub + longint'(mcin);
      rc = (ur >= (longint'(1) << W));
      sr = sa + sb + longint'(mcin);
    end
    rs = ur[W-1:0];
    ro = (sr > ((longint'(1) << (W - 1)) - 1)) || (sr < -(longint'(1) << (W - 1)));
    return {rs, rc, ro};
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // driver: call at a negedge with the DUT idle; returns at a negedge with the DUT idle
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic icin, input logic isub, input bit hold);
    int n;
    a     = ia;
    b     = ib;
    cin   = icin;
    sub   = isub;
    start = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(model(ia, ib, icin, isub));
    exp_t_q.push_back(cyc + NSLICE);
    if (!hold) start = 1'b0;
    n = 0;
    @(negedge clk);
    while (busy && n < 50) begin
      n++;
      if (hold) begin
        a   = W'($urandom);
        b   = W'($urandom);
        cin = 1'($urandom);
        sub = 1'($urandom);
      end
      @(negedge clk);
    end
    check("busy_cycles", n, NSLICE + 1);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          logic [RW-1:0] e;
          int et;
          e  = exp_q.pop_front();
          et = exp_t_q.pop_front();
          check("result", {sum, cout, ovf}, e);
          check("done_latency", cyc, et);
          last_res = e;
        end
      end else begin
        check("hold_outputs", {sum, cout, ovf}, last_res);
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;
    sub      = 1'b0;
    last_res = '0;
    #2;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_outs", {sum, cout, ovf}, 0);
    check("reset_state", dbg_state, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // directed cases
    issue(16'h0003, 16'h0002, 1'b1, 1'b0, 1'b0);
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    issue(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0);
    issue(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0);
    issue(16'h8000, 16'h8000, 1'b1, 1'b0, 1'b0);
    issue(16'h0000, 16'h8000, 1'b0, 1'b1, 1'b0);
    issue(16'h1234, 16'h1234, 1'b0, 1'b1, 1'b0);

    // start held through RUN with operands churning, then immediate back-to-back start
    issue(16'h4321, 16'h1111, 1'b1, 1'b0, 1'b1);
    issue(16'h0F0F, 16'hF0F1, 1'b0, 1'b1, 1'b0);

    // reset during the second RUN cycle
    a     = 16'hAAAA;
    b     = 16'h5555;
    cin   = 1'b1;
    sub   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_outs", {sum, cout, ovf}, 0);
    exp_q.delete();
    exp_t_q.delete();
    last_res = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0);

    // random operations, some with start held
    for (int i = 0; i < 40; i++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 3) == 0));
    end
    start = 1'b0;

    repeat (8) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rca_seq_ctrl.md
Name: rca_seq_ctrl

Overview:
Multi-cycle sequencer that adds or subtracts WIDTH-bit operands using one shared 4-bit ripple-carry adder, the team's `rca` module with ports a, b, cin, sum and cout.
- Captures the operands on a start pulse and presents one 4-bit slice per clock, LSB slice first.
- Chains the carry between slices through a register.
- Publishes a registered result with a one-cycle done strobe.
- Lets wide arithmetic reuse the small adder instead of building a WIDTH-bit ripple chain.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and at least 4.
- NSLICE, WIDTH/4, derived count of slices/RUN cycles. Not overridable.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  request pulse. Sampled only in IDLE.
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in for add. Ignored when sub=1.
- sub  in  1  0 = A+B+cin, 1 = A−B
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle strobe: result valid
- sum  out  WIDTH  registered result
- cout  out  1  carry out of the final slice. For sub, 1 means no borrow.
- ovf  out  1  two's-complement signed overflow

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy, done, sum, cout, ovf = 0; working registers, carry register and slice counter = 0.
- Clock and reset: one clock only, clk. Reset rst_n is asynchronous, active-low.
- FSM states: IDLE, RUN, DONE. busy = (state != IDLE).
- IDLE:
  - start=1 at a rising edge captures the operands: A_w=a; B_w = sub ? ~b : b; carry_r = sub ? 1 : cin.
  - Latches eff_b_msb = MSB of B_w. Clears slice counter k=0. Moves to RUN.
- RUN, at each edge:
  - Drive the rca with a=A_w[3:0], b=B_w[3:0], cin=carry_r.
  - Shift the rca sum into the MSB nibble of the working result (right shift by 4). carry_r <= rca cout.
  - Shift A_w and B_w right by 4. k <= k+1.
  - When k = NSLICE−1, go to DONE on the same edge and load the outputs:
    - sum <= completed working result.
    - cout <= final rca cout.
    - ovf <= (captured a MSB == eff_b_msb) && (sum MSB != captured a MSB).
- DONE: done=1 for exactly one cycle, then IDLE on the next edge.
- Latency: start sampled at edge E0. done is high between edges E_NSLICE and E_NSLICE+1; for WIDTH=16, that is 4 edges after capture. Minimum issue interval is NSLICE+2 cycles.
- Output holding:
  - sum, cout and ovf change only on entry to DONE.
  - They hold the previous result throughout a following RUN and until the next completion.
- Ignored inputs:
  - start in RUN or DONE is ignored. No queueing, no restart.
  - Changes to a, b, cin and sub after capture are ignored.
- Back-to-back: start asserted in the IDLE cycle that follows DONE is accepted.
- Reset mid-operation: abort immediately, all outputs zero, no done strobe for the aborted operation.
- Width rules:
  - Result wraps modulo 2^WIDTH.
  - cout is the true carry out of bit WIDTH−1.
  - Single-slice case WIDTH=4: RUN lasts exactly one cycle.

Test Plan:
1. WIDTH=16; a=0x0003, b=0x0002, cin=1, sub=0 → sum=0x0006, cout=0, ovf=0. done high exactly 4 edges after the start edge, for one cycle. busy high for 5 cycles.
2. a=0xFFFF, b=0x0001, cin=0, add → sum=0x0000, cout=1, ovf=0. Checks that the carry propagates through all 4 slices.
3. a=0x7FFF, b=0x0001, cin=0, add → sum=0x8000, cout=0, ovf=1. Then sub: a=0x0005, b=0x0007, cin=1 (ignored) → sum=0xFFFE, cout=0, ovf=0.
4. sub: a=0x8000, b=0x0001 → sum=0x7FFF, cout=1, ovf=1.
5. Hold start=1 through RUN while changing a/b → only the first operation executes, and its result is unaffected. sum holds the prior result during RUN. A new start in the IDLE cycle after DONE completes correctly.
6. Drive rst_n low during the second RUN cycle → busy, done, sum, cout and ovf go to 0 without waiting for a clock edge, with no done pulse. After release, a=0x1234, b=0x1111, add → sum=0x2345, cout=0, ovf=0.
